// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates RV32I conditional branches, computes the
// next PC and mispredict flag, and trains a table of 2-bit saturating counters
// that fetch reads for its predictions. A one-entry valid/ready stage holds
// each result.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct_3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic            out_mispredict,
  output logic            out_illegal,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_out
);

  localparam int IDX = $clog2(BHT_DEPTH);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, state_nxt;
  logic   accept;

  logic [1:0] bht [BHT_DEPTH];

  logic signed [XLEN-1:0] rs1_s_p0, rs2_s_p0;
  logic                   eq_p0, lt_s_p0, lt_u_p0;
  logic                   taken_p0, illegal_p0, mispredict_p0;
  logic [XLEN-1:0]        target_p0;
  logic [IDX-1:0]         upd_idx_p0, lkp_idx;
  logic                   unused_pred_pc;

  // 2-bit saturating counter step toward taken (up) or not-taken (down).
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    res = cnt;
    if (up && cnt != 2'b11)
      res = cnt + 2'b01;
    else if (!up && cnt != 2'b00)
      res = cnt - 2'b01;
    return res;
  endfunction

  // ---- stage p0: combinational resolve of the incoming request ----
  assign rs1_s_p0   = rs1;
  assign rs2_s_p0   = rs2;
  assign eq_p0      = (rs1 == rs2);
  assign lt_s_p0    = (rs1_s_p0 < rs2_s_p0);
  assign lt_u_p0    = (rs1 < rs2);
  assign upd_idx_p0 = pc[IDX+1:2];
  assign lkp_idx    = pred_pc[IDX+1:2];

  // Only the index bits of the lookup address matter.
  assign unused_pred_pc = ^{pred_pc[XLEN-1:IDX+2], pred_pc[1:0]};

  // Decode branch type into taken/illegal.
  always_comb begin
    taken_p0   = 1'b0;
    illegal_p0 = 1'b0;
    case (funct_3)
      3'b000:  taken_p0 = eq_p0;
      3'b001:  taken_p0 = ~eq_p0;
      3'b100:  taken_p0 = lt_s_p0;
      3'b101:  taken_p0 = ~lt_s_p0;
      3'b110:  taken_p0 = lt_u_p0;
      3'b111:  taken_p0 = ~lt_u_p0;
      default: illegal_p0 = 1'b1;
    endcase
  end

  assign target_p0     = taken_p0 ? (pc + imm) : (pc + XLEN'(4));
  assign mispredict_p0 = taken_p0 ^ pred_taken;

  // Output-stage state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  // Next state: a new accept always fills; otherwise drain on out_ready.
  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = FULL;
    else if (state == EMPTY || out_ready)
      state_nxt = EMPTY;
  end

  // Handshake outputs derived from the stage state.
  always_comb begin
    out_valid = (state == FULL);
    in_ready  = (state == EMPTY) | out_ready;
  end

  assign accept = in_valid & in_ready;

  // ---- stage p1: result register, loaded on accept, held otherwise ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_taken      <= 1'b0;
      out_target     <= '0;
      out_mispredict <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (accept) begin
      out_taken      <= taken_p0;
      out_target     <= target_p0;
      out_mispredict <= mispredict_p0;
      out_illegal    <= illegal_p0;
    end
  end

  // Counter table: weak-not-taken after reset, trained by legal accepted branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= 2'b01;
    end else if (accept && !illegal_p0) begin
      bht[upd_idx_p0] <= sat_update(bht[upd_idx_p0], taken_p0);
    end
  end

  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign pred_out = bht[lkp_idx][1];

endmodule
